led_pwm_fader: RTL
==================

// Module: led_pwm_fader
// PURPOSE
//   Downstream stage of the LED blinker. Consumes its 1-bit led level and drives the LED pin with PWM.
//   Brightness ramps linearly up and down instead of switching hard, giving a soft "breathing" blink.
//   Duty changes only on PWM period boundaries, so pwm_out never glitches mid-period.
// PARAMETERS
//   PWM_WIDTH  4  PWM counter width; period P = 2**PWM_WIDTH clocks; full-scale duty FULL = P
//   RAMP_DIV   2  duty steps by 1 every RAMP_DIV complete PWM periods; legal range >= 1
// PORTS
//   clk      in   1            clock, all logic on posedge
//   rst      in   1            reset, synchronous, active-high
//   led_in   in   1            requested LED level from blinker (same clock domain, no synchroniser)
//   pwm_out  out  1            registered PWM drive to LED pin
//   duty     out  PWM_WIDTH+1  current duty, 0..FULL
//   busy     out  1            high while in RAMP_UP or RAMP_DOWN
//   state_o  out  2            FSM state: 0 OFF, 1 RAMP_UP, 2 ON, 3 RAMP_DOWN
// BEHAVIOUR
//   Reset: state OFF, duty 0, pwm_cnt 0, div_cnt 0, pwm_out 0, busy 0. Reset overrides everything, including mid-ramp.
//   pwm_cnt: free-running 0..P-1, wraps to 0. boundary = (pwm_cnt == P-1).
//   pwm_out(n+1) = (pwm_cnt(n) < duty(n)), one-cycle latency.
//     duty 0 -> pwm_out constant 0; duty FULL -> constant 1.
//     Per period, exactly duty high cycles.
//   div_cnt (0..RAMP_DIV-1): counts boundaries during a ramp. Cleared on any state change.
//   FSM, evaluated every cycle; led_in checks take priority over stepping:
//     OFF:       led_in=1 -> RAMP_UP.
//     RAMP_UP:   led_in=0 -> RAMP_DOWN, keeping current duty, with no step in that cycle.
//                else on boundary: if div_cnt==RAMP_DIV-1, duty+1 and div_cnt 0, else div_cnt+1.
//                The step that makes duty==FULL also moves the state to ON.
//     ON:        duty held at FULL; led_in=0 -> RAMP_DOWN.
//     RAMP_DOWN: mirror of RAMP_UP. led_in=1 -> RAMP_UP.
//                Each step does duty-1; reaching 0 moves the state to OFF.
//   State changes one cycle after the led_in edge. duty never jumps: it changes by at most 1 per step and never under/overflows.
//   busy = (state==RAMP_UP || state==RAMP_DOWN), derived from registered state.
//   Full ramp time = FULL*RAMP_DIV periods (defaults: 16*2*16 = 512 clk), plus up to P-1 clk alignment.
//   led_in pulses shorter than one step: the ramp reverses in place. No lockout, no queueing.
// TESTING
//   1. rst held 3 clk with led_in=1 -> pwm_out=0, duty=0, state_o=0, busy=0; after release, state_o=1 on next clk.
//   2. led_in=1 held from OFF -> duty increments every 32 clk, reaches 16 within 544 clk, state_o=2, busy=0, pwm_out stays 1.
//   3. From ON drop led_in -> state_o=3 next clk; duty falls 16->0 in 512(+15) clk, state_o=0, pwm_out stays 0.
//   4. Reversal: raise led_in, drop it when duty==5 -> state_o=3, duty continues 5,4,...,0 with no jump or extra step.
//   5. Duty check: for every period during a ramp, count of pwm_out high cycles (offset by 1 clk) == duty of that period.
//   6. rst mid RAMP_UP (duty=7) -> next clk all outputs at reset values; PWM_WIDTH=2, RAMP_DIV=1 rerun of tests 2-3 passes.

Source files
------------

// File: rtl/led_pwm_fader.sv
// LED PWM fader: turns the blinker's hard on/off level into a PWM drive whose duty
// ramps linearly, updating duty only on PWM period boundaries.
module led_pwm_fader #(
    parameter int PWM_WIDTH = 4,
    parameter int RAMP_DIV  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led_in,
    output logic                 pwm_out,
    output logic [PWM_WIDTH:0]   duty,
    output logic                 busy,
    output logic [1:0]           state_o
);

    localparam int                   P       = 2 ** PWM_WIDTH;
    localparam int                   DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_WIDTH:0]   FULL    = (PWM_WIDTH + 1)'(P);
    localparam logic [PWM_WIDTH:0]   FULL_M1 = (PWM_WIDTH + 1)'(P - 1);
    localparam logic [PWM_WIDTH:0]   ONE     = (PWM_WIDTH + 1)'(1);
    localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [DIV_W-1:0]     DIV_MAX = DIV_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t                 r_state;
    logic [PWM_WIDTH:0]     r_duty;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [PWM_WIDTH-1:0]   r_pwm_cnt;
    logic                   r_pwm_out;

    state_t                 w_state_nxt;
    logic [PWM_WIDTH:0]     w_duty_nxt;
    logic [DIV_W-1:0]       w_div_nxt;
    logic                   w_boundary;

    // Saturating duty steps: duty can never leave 0..FULL whatever the FSM asks for.
    function automatic logic [PWM_WIDTH:0] f_duty_inc(input logic [PWM_WIDTH:0] d);
        return (d >= FULL) ? FULL : d + ONE;
    endfunction

    function automatic logic [PWM_WIDTH:0] f_duty_dec(input logic [PWM_WIDTH:0] d);
        return (d == '0) ? '0 : d - ONE;
    endfunction

    assign w_boundary = (r_pwm_cnt == CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_div_nxt   = r_div_cnt;
        case (r_state)
            S_OFF: begin
                if (led_in) begin
                    w_state_nxt = S_RAMP_UP;
                    w_div_nxt   = '0;
                end
            end
            S_RAMP_UP: begin
                if (!led_in) begin
                    w_state_nxt = S_RAMP_DOWN;
                    w_div_nxt   = '0;
                end else if (r_duty >= FULL) begin
                    w_state_nxt = S_ON;
                    w_div_nxt   = '0;
                end else if (w_boundary) begin
                    if (r_div_cnt == DIV_MAX) begin
                        w_duty_nxt = f_duty_inc(r_duty);
                        w_div_nxt  = '0;
                        if (r_duty == FULL_M1) w_state_nxt = S_ON;
                    end else begin
                        w_div_nxt = r_div_cnt + 1'b1;
                    end
                end
            end
            S_ON: begin
                w_duty_nxt = FULL;
                if (!led_in) begin
                    w_state_nxt = S_RAMP_DOWN;
                    w_div_nxt   = '0;
                end
            end
            S_RAMP_DOWN: begin
                // A reversal right after leaving OFF can land here with duty already 0.
                if (led_in) begin
                    w_state_nxt = S_RAMP_UP;
                    w_div_nxt   = '0;
                end else if (r_duty == '0) begin
                    w_state_nxt = S_OFF;
                    w_div_nxt   = '0;
                end else if (w_boundary) begin
                    if (r_div_cnt == DIV_MAX) begin
                        w_duty_nxt = f_duty_dec(r_duty);
                        w_div_nxt  = '0;
                        if (r_duty == ONE) w_state_nxt = S_OFF;
                    end else begin
                        w_div_nxt = r_div_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_OFF;
                w_duty_nxt  = '0;
                w_div_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_OFF;
            r_duty    <= '0;
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
            r_pwm_out <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_duty    <= w_duty_nxt;
            r_div_cnt <= w_div_nxt;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_pwm_out <= ({1'b0, r_pwm_cnt} < r_duty);
        end
    end

    assign pwm_out = r_pwm_out;
    assign duty    = r_duty;
    assign state_o = r_state;
    assign busy    = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);

endmodule
